run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl.sv | 138 +++++++++++++
 tb/tb_run_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run/restart sequencer: reset hold, counted run with tick divider, done latch
module run_ctrl #(
   parameter int CLK_HZ     = 12000000,
   parameter int RUN_CYCLES = 50000,
   parameter int RST_HOLD   = 16,
   parameter int TICK_HZ    = 1000,
   parameter int CNT_W      = 32
) (
   input  logic             CLOCK_12M,
   input  logic             RESET_N,
   input  logic             start,
   input  logic             pause,
   output logic             sys_rst_n,
   output logic             run_en,
   output logic             tick,
   output logic [CNT_W-1:0] cycle_count,
   output logic             done,
   output logic [1:0]       state
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int DIV_W    = $clog2(TICK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
   localparam logic [7:0]       HOLD_LAST = 8'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(RUN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   // A zero run limit means the run never terminates on count.
   localparam bit               LIMITED   = (RUN_CYCLES != 0);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_t;

   state_t           state_q,     state_d;
   logic [7:0]       hold_q,      hold_d;
   logic [DIV_W-1:0] div_q,       div_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             tick_q,      tick_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             done_q,      done_d;
   logic [CNT_W-1:0] cnt_inc;

   // Saturating increment: with a limit the run stops before this can wrap,
   // without one the count must pin at all-ones.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   // Next-state logic; start overrides everything, including terminal count and pause.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;

      if (start) begin
         state_d = ST_HOLD;
         hold_d  = 8'd0;
         div_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               // Pause is ignored here so the hold length is always RST_HOLD cycles.
               if (hold_q == HOLD_LAST) begin
                  state_d = ST_RUN;
                  hold_d  = 8'd0;
               end else begin
                  hold_d = hold_q + 8'd1;
               end
            end
            ST_RUN: begin
               if (!pause) begin
                  if (div_q == DIV_LAST) begin
                     div_d  = '0;
                     tick_d = 1'b1;
                  end else begin
                     div_d = div_q + DIV_ONE;
                  end
                  cnt_d = cnt_inc;
                  if (LIMITED && (cnt_inc == RUN_LIMIT)) begin
                     state_d = ST_DONE;
                     // No tick is ever shown while DONE.
                     tick_d  = 1'b0;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_HOLD;
               hold_d  = 8'd0;
               div_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end

      // Registered outputs follow the state being entered, so they line up with state.
      sys_rst_n_d = (state_d != ST_HOLD);
      done_d      = (state_d == ST_DONE);
   end

   // State and registered outputs; RESET_N aborts any run immediately.
   always_ff @(posedge CLOCK_12M or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_HOLD;
         hold_q      <= 8'd0;
         div_q       <= '0;
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         sys_rst_n_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         sys_rst_n_q <= sys_rst_n_d;
         done_q      <= done_d;
      end
   end

   assign run_en      = (state_q == ST_RUN) && !pause;
   assign sys_rst_n   = sys_rst_n_q;
   assign tick        = tick_q;
   assign cycle_count = cnt_q;
   assign done        = done_q;
   assign state       = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - randomized and directed bench for run_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_run_ctrl;

   localparam int S_HOLD = 0;
   localparam int S_RUN  = 1;
   localparam int S_DONE = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start;
   logic pause;

   logic        a_sys_rst_n, a_run_en, a_tick, a_done;
   logic [15:0] a_count;
   logic [1:0]  a_state;
   logic        b_sys_rst_n, b_run_en, b_tick, b_done;
   logic [7:0]  b_count;
   logic [1:0]  b_state;

   // A: limited run, TICK_DIV = 120, 500 cycles, hold 16.
   run_ctrl #(.CLK_HZ(120000), .RUN_CYCLES(500), .RST_HOLD(16), .TICK_HZ(1000), .CNT_W(16)) u_a (
      .CLOCK_12M(clk), .RESET_N(rst_n), .start(start), .pause(pause),
      .sys_rst_n(a_sys_rst_n), .run_en(a_run_en), .tick(a_tick),
      .cycle_count(a_count), .done(a_done), .state(a_state));

   // B: unlimited run, 8-bit counter, TICK_DIV = 7, hold 3.
   run_ctrl #(.CLK_HZ(7000), .RUN_CYCLES(0), .RST_HOLD(3), .TICK_HZ(1000), .CNT_W(8)) u_b (
      .CLOCK_12M(clk), .RESET_N(rst_n), .start(start), .pause(pause),
      .sys_rst_n(b_sys_rst_n), .run_en(b_run_en), .tick(b_tick),
      .cycle_count(b_count), .done(b_done), .state(b_state));

   int     checks = 0;
   int     errors = 0;
   bit     chk_en = 1'b0;

   int     p_lim  [2] = '{500, 0};
   int     p_hold [2] = '{16, 3};
   int     p_div  [2] = '{120, 7};
   longint p_max  [2] = '{65535, 255};

   int     m_state [2];
   int     m_hold  [2];
   longint m_adv   [2];
   bit     m_tick  [2];

   task automatic chk(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
      end
   endtask

   function automatic longint m_count(input int k);
      return (m_adv[k] > p_max[k]) ? p_max[k] : m_adv[k];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = S_HOLD;
         m_hold[k]  = 0;
         m_adv[k]   = 0;
         m_tick[k]  = 1'b0;
      end
   endtask

   // m_adv counts every unpaused RUN cycle since (re)start; the visible count is
   // that number clipped, and a tick follows every TICK_DIV-th such cycle.
   task automatic model_step(input bit s, input bit p);
      for (int k = 0; k < 2; k++) begin
         m_tick[k] = 1'b0;
         if (s) begin
            m_state[k] = S_HOLD;
            m_hold[k]  = 0;
            m_adv[k]   = 0;
         end else if (m_state[k] == S_HOLD) begin
            m_hold[k]++;
            if (m_hold[k] == p_hold[k]) begin
               m_state[k] = S_RUN;
               m_hold[k]  = 0;
            end
         end else if (m_state[k] == S_RUN && !p) begin
            m_adv[k]++;
            if (p_lim[k] != 0 && m_adv[k] == longint'(p_lim[k]))
               m_state[k] = S_DONE;
            else if (m_adv[k] % p_div[k] == 0)
               m_tick[k] = 1'b1;
         end
      end
   endtask

   always @(posedge clk) if (rst_n === 1'b1) model_step(start, pause);
   always @(negedge rst_n) model_reset();

   // Compare every cycle, away from the clock edge.
   always @(negedge clk) begin
      #1;
      if (chk_en) begin
         chk("a.state",     a_state,     m_state[0]);
         chk("a.sys_rst_n", a_sys_rst_n, m_state[0] != S_HOLD);
         chk("a.done",      a_done,      m_state[0] == S_DONE);
         chk("a.count",     a_count,     m_count(0));
         chk("a.tick",      a_tick,      m_tick[0]);
         chk("a.run_en",    a_run_en,    m_state[0] == S_RUN && !pause);
         chk("b.state",     b_state,     m_state[1]);
         chk("b.sys_rst_n", b_sys_rst_n, m_state[1] != S_HOLD);
         chk("b.done",      b_done,      m_state[1] == S_DONE);
         chk("b.count",     b_count,     m_count(1));
         chk("b.tick",      b_tick,      m_tick[1]);
         chk("b.run_en",    b_run_en,    m_state[1] == S_RUN && !pause);
      end
   end

   // Apply inputs for the next rising edge and advance to the following falling edge.
   task automatic step(input bit s, input bit p);
      start = s;
      pause = p;
      @(negedge clk);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, ".a.state"},     a_state,     0);
      chk({tag, ".a.count"},     a_count,     0);
      chk({tag, ".a.sys_rst_n"}, a_sys_rst_n, 0);
      chk({tag, ".a.done"},      a_done,      0);
      chk({tag, ".a.tick"},      a_tick,      0);
      chk({tag, ".a.run_en"},    a_run_en,    0);
      chk({tag, ".b.state"},     b_state,     0);
      chk({tag, ".b.count"},     b_count,     0);
      chk({tag, ".b.sys_rst_n"}, b_sys_rst_n, 0);
   endtask

   int rise_e;
   int done_e;
   int n_ticks;
   int ticks_after_done;
   int max_count;
   int tick_at [$];
   int want_tick;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_values("reset");
      chk_en = 1'b1;

      // Directed run: release reset, pause 100 cycles once count reaches 100.
      rst_n = 1'b1;
      rise_e = 0; done_e = 0; n_ticks = 0; ticks_after_done = 0; max_count = 0;
      for (int e = 1; e <= 700; e++) begin
         step(1'b0, (e >= 117 && e <= 216));
         if (a_sys_rst_n && rise_e == 0) rise_e = e;
         if (a_tick) begin
            if (done_e != 0) ticks_after_done++;
            else begin
               n_ticks++;
               tick_at.push_back(int'(a_count));
            end
         end
         if (a_done && done_e == 0) done_e = e;
         if (int'(a_count) > max_count) max_count = int'(a_count);
      end
      chk("lit.rst_rise_edge", rise_e, 16);
      chk("lit.done_edge", done_e, 616);
      chk("lit.ticks_before_done", n_ticks, 4);
      chk("lit.ticks_after_done", ticks_after_done, 0);
      chk("lit.max_count", max_count, 500);
      want_tick = 120;
      foreach (tick_at[i]) begin
         chk("lit.tick_count", tick_at[i], want_tick);
         want_tick += 120;
      end
      chk("lit.b_saturated", b_count, 255);
      chk("lit.b_done", b_done, 0);

      // Restart from DONE.
      step(1'b1, 1'b0);
      chk("lit.restart.state", a_state, 0);
      chk("lit.restart.count", a_count, 0);
      chk("lit.restart.sys_rst_n", a_sys_rst_n, 0);
      chk("lit.restart.done", a_done, 0);
      rise_e = 0;
      for (int k = 1; k <= 515; k++) begin
         step(1'b0, 1'b0);
         if (a_sys_rst_n && rise_e == 0) rise_e = k;
      end
      chk("lit.restart.rise_edge", rise_e, 16);
      chk("lit.pre_terminal.count", a_count, 499);

      // Start collides with the terminal-count cycle.
      step(1'b1, 1'b0);
      chk("lit.collide.state", a_state, 0);
      chk("lit.collide.done", a_done, 0);
      chk("lit.collide.count", a_count, 0);

      // Randomized traffic.
      for (int k = 0; k < 3000; k++)
         step($urandom_range(0, 999) == 0, $urandom_range(0, 3) == 0);

      // Asynchronous reset in the middle of a run.
      step(1'b1, 1'b0);
      repeat (40) step(1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_values("async");
      @(negedge clk);
      repeat (2) step(1'b0, 1'b0);
      rst_n = 1'b1;
      rise_e = 0;
      for (int k = 1; k <= 30; k++) begin
         step(1'b0, $urandom_range(0, 1) == 1);
         if (a_sys_rst_n && rise_e == 0) rise_e = k;
      end
      chk("lit.after_reset.rise_edge", rise_e, 16);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
